// File: rtl/mem_access_pkg.sv
// Shared encodings for the sub-word memory access unit.
// Access size codes and the store read-modify-write state machine states.
package mem_access_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering between byte-addressed requests and 32-bit memory words.
// Purely combinational: load extraction/extension and store lane merge.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

        case (i_size)
            SIZE_B:  o_load = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_H:  o_load = {{16{i_signed & w_half[15]}}, w_half};
            default: o_load = i_rdata;
        endcase

        // Only the addressed lane(s) change; the rest keep the word read from memory.
        o_merged = i_rdata;
        case (i_size)
            SIZE_B:  o_merged[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
            SIZE_H:  o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata;
            default: o_merged = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store adapter in front of a word-only data memory.
// Loads and word stores are single cycle; sub-word stores read-modify-write over two cycles.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        exc_misalign,
    output logic [31:0] bad_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_merged;
    logic [31:0] r_bad_addr;

    logic        w_fault;
    logic        w_sub_store;
    logic [31:0] w_word_addr;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_word_addr = {req_addr[31:2], 2'b00};
    assign w_sub_store = req_we && (req_size == SIZE_B || req_size == SIZE_H);
    assign bad_addr    = r_bad_addr;

    always_comb begin
        case (req_size)
            SIZE_B:  w_fault = 1'b0;
            SIZE_H:  w_fault = req_addr[0];
            SIZE_W:  w_fault = (req_addr[1:0] != 2'b00);
            default: w_fault = 1'b1;
        endcase
    end

    mem_lane_align u_align (
        .i_size    (req_size),
        .i_signed  (req_signed),
        .i_addr_lo (req_addr[1:0]),
        .i_rdata   (mem_rdata),
        .i_wdata   (req_wdata[15:0]),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    // In WRITE the inputs still show the consumed store, so they are ignored.
    always_comb begin
        load_data    = 32'd0;
        stall        = 1'b0;
        exc_misalign = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        if (reset) begin
            load_data = 32'd0;
        end else if (r_state == ST_WRITE) begin
            mem_wr    = 1'b1;
            mem_addr  = r_addr;
            mem_wdata = r_merged;
        end else if (req_valid) begin
            if (w_fault) begin
                exc_misalign = 1'b1;
            end else if (!req_we) begin
                mem_rd    = 1'b1;
                mem_addr  = w_word_addr;
                load_data = w_load;
            end else if (req_size == SIZE_W) begin
                mem_wr    = 1'b1;
                mem_addr  = w_word_addr;
                mem_wdata = req_wdata;
            end else begin
                mem_rd   = 1'b1;
                stall    = 1'b1;
                mem_addr = w_word_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= 32'd0;
            r_merged   <= 32'd0;
            r_bad_addr <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && w_fault) begin
                        r_bad_addr <= req_addr;
                    end else if (req_valid && w_sub_store) begin
                        r_merged <= w_merged;
                        r_addr   <= w_word_addr;
                        r_state  <= ST_WRITE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand sequences, and randomized
// accesses checked against a byte-array reference memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        exc_misalign;
    logic [31:0] bad_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic [7:0]  ref_mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    mem_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .load_data    (load_data),
        .stall        (stall),
        .exc_misalign (exc_misalign),
        .bad_addr     (bad_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_load;
        logic        exp_exc;
        logic        exp_rd;
        logic        exp_wr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; the bench memory commits whatever write the DUT presented.
    task automatic step();
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        w = mem_wr;
        a = mem_addr;
        d = mem_wdata;
        @(posedge clk);
        if (w) mem[a[7:2]] = d;
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a[7:0] + k]) << (8 * k));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[idx*4+3], ref_mem[idx*4+2], ref_mem[idx*4+1], ref_mem[idx*4]};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int k = 0; k < (1 << sz); k++) ref_mem[a[7:0] + k] = wd[8*k +: 8];
    endtask

    vec_t vecs [0:7];

    initial begin
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        fault;

        vecs[0] = '{1'b0, 2'b00, 1'b1, 32'h01, 32'h0, 32'hFFFF_FFF2, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 2'b00, 1'b0, 32'h03, 32'h0, 32'h0000_0080, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 32'hFFFF_8081, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 2'b10, 1'b1, 32'h00, 32'h0, 32'h8081_F27F, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 2'b01, 1'b0, 32'h00, 32'h0, 32'h0000_F27F, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 2'b01, 1'b0, 32'h03, 32'hBEEF, 32'h0,      1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 2'b11, 1'b0, 32'h44, 32'h0, 32'h0,         1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[0] = 32'h8081_F27F;

        // Reset with a sub-word store pending on the inputs: nothing may move.
        reset = 1'b1;
        drive(1'b1, 2'b00, 1'b0, 32'h12, 32'hAB);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rd", {31'd0, mem_rd}, 32'd0);
        step();
        step();
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        #1;
        chk("rst_outs", {load_data[30:0] | mem_addr[30:0] | mem_wdata[30:0] | bad_addr[30:0],
                         stall | exc_misalign | mem_rd | mem_wr | load_data[31] | mem_addr[31]
                         | mem_wdata[31] | bad_addr[31]}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("v%0d_load", i), load_data, vecs[i].exp_load);
            chk($sformatf("v%0d_exc", i), {31'd0, exc_misalign}, {31'd0, vecs[i].exp_exc});
            chk($sformatf("v%0d_rd", i), {31'd0, mem_rd}, {31'd0, vecs[i].exp_rd});
            chk($sformatf("v%0d_wr", i), {31'd0, mem_wr}, {31'd0, vecs[i].exp_wr});
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
            step();
            if (vecs[i].exp_exc) chk($sformatf("v%0d_bad", i), bad_addr, vecs[i].addr);
        end

        // Byte store read-modify-write.
        mem[4] = 32'h1122_3344;
        drive(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFAB);
        #1;
        chk("sb_c1_stall", {31'd0, stall}, 32'd1);
        chk("sb_c1_rd", {31'd0, mem_rd}, 32'd1);
        chk("sb_c1_addr", mem_addr, 32'h10);
        step();
        chk("sb_c2_wr", {31'd0, mem_wr}, 32'd1);
        chk("sb_c2_rd_stall", {30'd0, mem_rd, stall}, 32'd0);
        chk("sb_c2_wdata", mem_wdata, 32'h11AB_3344);
        step();
        req_valid = 1'b0;
        chk("sb_readback", mem[4], 32'h11AB_3344);

        // Halfword store followed directly by a word store to the same word.
        mem[8] = 32'd0;
        drive(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF);
        #1;
        chk("shsw_c1_stall", {31'd0, stall}, 32'd1);
        step();
        chk("shsw_c2_wr", {31'd0, mem_wr}, 32'd1);
        chk("shsw_c2_wdata", mem_wdata, 32'hBEEF_0000);
        chk("shsw_c2_stall", {31'd0, stall}, 32'd0);
        step();
        drive(1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678);
        #1;
        chk("shsw_c3_wr", {31'd0, mem_wr}, 32'd1);
        chk("shsw_c3_wdata", mem_wdata, 32'h1234_5678);
        chk("shsw_c3_stall", {31'd0, stall}, 32'd0);
        step();
        req_valid = 1'b0;
        chk("shsw_readback", mem[8], 32'h1234_5678);

        // Reset landing in the WRITE cycle drops the pending write.
        mem[12] = 32'hCAFE_F00D;
        drive(1'b1, 2'b00, 1'b0, 32'h31, 32'h55);
        #1;
        step();
        reset = 1'b1;
        #1;
        chk("rmw_rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("rmw_rst_stall", {31'd0, stall}, 32'd0);
        step();
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        #1;
        chk("rmw_rst_idle", {29'd0, mem_wr, mem_rd, stall}, 32'd0);
        chk("rmw_rst_bad", bad_addr, 32'd0);
        chk("rmw_rst_mem", mem[12], 32'hCAFE_F00D);

        // Idle for ten cycles.
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle%0d", i),
                load_data | mem_addr | mem_wdata | {28'd0, stall, exc_misalign, mem_rd, mem_wr}, 32'd0);
        end

        // Randomized accesses against the byte-level reference memory.
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            for (int k = 0; k < 4; k++) ref_mem[i*4+k] = mem[i][8*k +: 8];
        end
        for (int t = 0; t < 400; t++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 255));
            wd = $urandom;
            fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
            drive(we, sz, sg, a, wd);
            #1;
            chk($sformatf("r%0d_exc", t), {31'd0, exc_misalign}, {31'd0, fault});
            if (fault) begin
                chk($sformatf("r%0d_fstrobe", t), {29'd0, mem_rd, mem_wr, stall}, 32'd0);
                step();
                chk($sformatf("r%0d_bad", t), bad_addr, a);
            end else if (!we) begin
                chk($sformatf("r%0d_load", t), load_data, ref_load(a, sz, sg));
                chk($sformatf("r%0d_lstrobe", t), {29'd0, mem_rd, mem_wr, stall}, 32'b100);
                step();
            end else if (sz == 2'b10) begin
                ref_store(a, sz, wd);
                chk($sformatf("r%0d_sw", t), {29'd0, mem_rd, mem_wr, stall}, 32'b010);
                chk($sformatf("r%0d_sw_data", t), mem_wdata, wd);
                step();
            end else begin
                chk($sformatf("r%0d_st1", t), {29'd0, mem_rd, mem_wr, stall}, 32'b101);
                chk($sformatf("r%0d_st1_load", t), load_data, 32'd0);
                step();
                ref_store(a, sz, wd);
                chk($sformatf("r%0d_st2", t), {29'd0, mem_rd, mem_wr, stall}, 32'b010);
                chk($sformatf("r%0d_st2_addr", t), mem_addr, {a[31:2], 2'b00});
                chk($sformatf("r%0d_st2_data", t), mem_wdata, ref_word(int'(a[7:2])));
                step();
            end
        end
        req_valid = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) chk($sformatf("final_w%0d", i), mem[i], ref_word(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
